// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, device-clocked frame shift, ACK check.
// Both lines are open-drain; the *_Drive_Low outputs pull a line low, release lets the pull-up win.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES     = 5000,
    parameter int FIRST_EDGE_TIMEOUT = 750000,
    parameter int EDGE_TIMEOUT       = 100000
) (
    input  logic       Fast_Clock,
    input  logic       Reset,
    input  logic       Send,
    input  logic [7:0] Tx_Byte,
    output logic       Busy,
    output logic       Done,
    output logic       Error,
    input  logic       KB_Clk,
    input  logic       KB_Data,
    output logic       KB_Clk_Drive_Low,
    output logic       KB_Data_Drive_Low
);

    localparam int MAX_A   = (INHIBIT_CYCLES > FIRST_EDGE_TIMEOUT) ? INHIBIT_CYCLES : FIRST_EDGE_TIMEOUT;
    localparam int MAX_CNT = (MAX_A > EDGE_TIMEOUT) ? MAX_A : EDGE_TIMEOUT;
    localparam int CW      = $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0] LD_INH   = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] LD_FIRST = CW'(FIRST_EDGE_TIMEOUT - 1);
    localparam logic [CW-1:0] LD_EDGE  = CW'(EDGE_TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE,
        INHIBIT,
        RTS,
        WAIT_FIRST,
        SHIFT,
        ACK,
        WAIT_IDLE,
        DONE,
        ERR
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [9:0]    shreg, shreg_next;
    logic [3:0]    bit_cnt, bit_cnt_next;

    logic clk_s1, clk_s2, clk_prev;
    logic data_s1, data_s2;
    logic fall;

    // Synchronizers preset high so a reset never fabricates a falling edge.
    always_ff @(posedge Fast_Clock or posedge Reset) begin
        if (Reset) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            data_s1  <= 1'b1;
            data_s2  <= 1'b1;
        end else begin
            clk_s1   <= KB_Clk;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            data_s1  <= KB_Data;
            data_s2  <= data_s1;
        end
    end

    assign fall = clk_prev & ~clk_s2;

    always_ff @(posedge Fast_Clock or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            cnt     <= '0;
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            shreg   <= shreg_next;
            bit_cnt <= bit_cnt_next;
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        shreg_next   = shreg;
        bit_cnt_next = bit_cnt;
        case (state)
            IDLE: begin
                if (Send) begin
                    state_next   = INHIBIT;
                    shreg_next   = {1'b1, ~^Tx_Byte, Tx_Byte};
                    bit_cnt_next = '0;
                    cnt_next     = LD_INH;
                end
            end
            INHIBIT: begin
                if (cnt == '0) state_next = RTS;
                else           cnt_next   = cnt - CW'(1);
            end
            RTS: begin
                state_next = WAIT_FIRST;
                cnt_next   = LD_FIRST;
            end
            WAIT_FIRST: begin
                if (fall) begin
                    state_next   = SHIFT;
                    bit_cnt_next = 4'd1;
                    cnt_next     = LD_EDGE;
                end else if (cnt == '0) begin
                    state_next = ERR;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            SHIFT: begin
                // Stop bit shifts in behind the frame, so edge 10 leaves the line released.
                if (fall) begin
                    shreg_next   = {1'b1, shreg[9:1]};
                    bit_cnt_next = bit_cnt + 4'd1;
                    cnt_next     = LD_EDGE;
                    if (bit_cnt == 4'd9) state_next = ACK;
                end else if (cnt == '0) begin
                    state_next = ERR;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            ACK: begin
                if (fall) begin
                    state_next = data_s2 ? ERR : WAIT_IDLE;
                    cnt_next   = LD_EDGE;
                end else if (cnt == '0) begin
                    state_next = ERR;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            WAIT_IDLE: begin
                if (clk_s2 && data_s2) state_next = DONE;
                else if (cnt == '0)    state_next = ERR;
                else                   cnt_next   = cnt - CW'(1);
            end
            DONE:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Moore outputs straight from the state register, so reset releases the lines at once.
    assign Busy              = (state != IDLE);
    assign Done              = (state == DONE);
    assign Error             = (state == ERR);
    assign KB_Clk_Drive_Low  = (state == INHIBIT) || (state == RTS);
    assign KB_Data_Drive_Low = (state == RTS) || (state == WAIT_FIRST) ||
                               ((state == SHIFT) && !shreg[0]);

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: the send-side counterpart of the PS2 keyboard receiver on the shared KB_Clk/KB_Data pair.
- Lets the processor's IO path send command bytes to the keyboard, e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable.
- Drives both lines open-drain through active-high "drive low" enables. A line reads high when released (external pull-up).
- Generates the request-to-send sequence, shifts the frame on device-generated clock edges and checks the device acknowledge.

Parameters:
- INHIBIT_CYCLES, 5000: Fast_Clock cycles KB_Clk is held low before request-to-send (100 us at 50 MHz).
- FIRST_EDGE_TIMEOUT, 750000: max cycles from clock release to the first device falling edge (15 ms).
- EDGE_TIMEOUT, 100000: max cycles between consecutive device falling edges, and for the final line-idle wait (2 ms).

Ports:
- Fast_Clock  in  1  system clock; all state updates on posedge.
- Reset  in  1  asynchronous, active-high reset.
- Send  in  1  one-cycle request; sampled only when Busy=0.
- Tx_Byte  in  8  byte to send; latched on accepted Send.
- Busy  out  1  high from the cycle after an accepted Send until the Done/Error cycle, inclusive.
- Done  out  1  one-cycle pulse: frame sent and ACK seen.
- Error  out  1  one-cycle pulse: timeout or missing ACK.
- KB_Clk  in  1  raw PS/2 clock line level.
- KB_Data  in  1  raw PS/2 data line level.
- KB_Clk_Drive_Low  out  1  1 = pull KB_Clk low.
- KB_Data_Drive_Low  out  1  1 = pull KB_Data low.

Behaviour:
- Reset: async, active-high; single clock Fast_Clock.
  - All outputs 0 immediately; state IDLE; counters 0; synchronizers preset to 1.
  - Reset mid-frame releases both lines at once. No Done or Error is pulsed.
- Input conditioning: KB_Clk and KB_Data pass through 2-FF synchronizers.
  - A falling edge = previous synced clock 1 and current synced clock 0. It is acted on the cycle it is detected.
- Frame encoding:
  - Shift register holds {1 (stop), P, Tx_Byte[7:0]}, sent LSB first.
  - P = ~^Tx_Byte (odd parity).
  - Bit counter runs 0..10.
- States and transitions:
  - IDLE: on Send=1, latch byte, go to INHIBIT. Busy=1 and KB_Clk_Drive_Low=1 from the next cycle.
  - INHIBIT: clock driven low for exactly INHIBIT_CYCLES cycles, then go to RTS.
  - RTS: one cycle with both drive-lows = 1, then go to WAIT_FIRST.
  - WAIT_FIRST: clock released, data held low (start bit). Watchdog counts up. Falling edge -> SHIFT with bit 0 placed on the line. Watchdog reaching FIRST_EDGE_TIMEOUT -> ERR.
  - SHIFT: on each falling edge, present the next bit.
    - KB_Data_Drive_Low = ~bit.
    - Edges 1..8 present data bits 0..7.
    - Edge 9 presents parity.
    - Edge 10 releases data (stop bit), then go to ACK.
    - Watchdog clears on every edge. Reaching EDGE_TIMEOUT -> ERR.
  - ACK: on the next falling edge (edge 11), sample synced data. 0 -> WAIT_IDLE; 1 -> ERR. EDGE_TIMEOUT -> ERR.
  - WAIT_IDLE: wait until synced clock and data are both 1, then go to DONE. EDGE_TIMEOUT -> ERR.
  - DONE: Done=1 for one cycle, Busy then falls, go to IDLE.
  - ERR: release both lines, Error=1 for one cycle, Busy then falls, go to IDLE.
- Outcome signals: Done and Error are never high together. Busy is 1 during the DONE/ERR cycle.
- Send while Busy=1 is ignored and not queued. Tx_Byte changes after acceptance have no effect.
- Once INHIBIT is left, KB_Clk_Drive_Low is never asserted again in that frame.

Test Plan:
- Send with Tx_Byte=0xED, device model clocking at 12 kHz and ACKing.
  - Required: data after edges 1..10 = 1,0,1,1,0,1,1,1, P=1, then released.
  - Required: KB_Clk_Drive_Low high exactly 5001 cycles; Done one pulse; Busy falls after it.
- Parity corners: 0x00 -> P=1; 0xFF -> P=1; 0x01 -> P=0. Each ends with Done.
- Device releases data at edge 11 (no ACK) -> Error pulse, no Done, both drive-lows 0, back to IDLE.
- No device clock after RTS -> Error exactly FIRST_EDGE_TIMEOUT cycles after clock release.
- Device stops after edge 4 -> Error EDGE_TIMEOUT cycles after edge 4.
- Send=1 with Tx_Byte=0x55 mid-frame of 0xF4 -> ignored; captured frame bits match 0xF4 only.
- Reset asserted after edge 6 -> both drive-lows 0 in the same cycle, no Done/Error.
  - A subsequent Send 0xFF -> frame completes normally.
